audio_sample_scheduler: RTL
===========================

# audio_sample_scheduler

Per-sample sequencer between the SPI sample receiver, the signal processor and the delta-sigma DAC. It accepts one received PCM word, launches a single DSP transaction on it and waits for completion with a timeout. The result goes into a small FIFO, which it drains to the DAC at a fixed sample-rate tick derived from `input_clk`. It owns flow control between the asynchronous SPI arrival rate and the fixed DAC rate: drop on overrun, hold/mute on underrun, sticky error flags for the status LEDs.

## Interface
- `DATA_W`, 16, PCM sample width
- `FIFO_DEPTH`, 4, result FIFO entries (power of two, ≥2)
- `RATE_DIV`, 256, `input_clk` cycles per output sample (12.288 MHz / 256 = 48 kHz)
- `DSP_TIMEOUT`, 64, max cycles waiting for `dsp_done`
- `MUTE_AFTER`, 8, consecutive underruns before output is forced to 0
- `input_clk`  in  1  system clock, 12.288 MHz; one clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rx_valid`  in  1  one-cycle pulse: `rx_data` holds a new sample (already in `input_clk` domain)
- `rx_data`  in  DATA_W  received PCM sample
- `dsp_start`  out  1  one-cycle pulse launching the DSP on `dsp_data`
- `dsp_data`  out  DATA_W  operand to DSP, stable from `dsp_start` until `dsp_done`
- `dsp_done`  in  1  one-cycle pulse: `dsp_result` valid
- `dsp_result`  in  DATA_W  processed sample
- `pcm_out`  out  DATA_W  sample to DAC, changes only on `sample_tick`
- `sample_tick`  out  1  one-cycle pulse every RATE_DIV cycles
- `clear_flags`  in  1  clears sticky flags
- `overrun_flag`, `underrun_flag`, `timeout_flag`  out  1 each  sticky error flags
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE.
- IDLE: on `rx_valid`, latch `rx_data` into `dsp_data`; go to ISSUE.
- ISSUE: assert `dsp_start` for exactly one cycle, clear the timeout counter; go to WAIT.
- WAIT: on `dsp_done`, capture `dsp_result`; go to WRITE. If the timeout counter reaches DSP_TIMEOUT−1 without `dsp_done`, set `timeout_flag`, discard the sample and return to IDLE. A `dsp_done` seen outside WAIT is ignored.
- WRITE: push the captured result if the FIFO is not full. If full, discard it and set `overrun_flag`. Return to IDLE.
- `rx_valid` arriving in any state other than IDLE: the sample is dropped and `overrun_flag` is set. The in-flight sample is unaffected.
- Tick counter runs 0..RATE_DIV−1 and wraps. `sample_tick` is asserted when the count equals RATE_DIV−1.
- On `sample_tick` with the FIFO non-empty: pop the head into `pcm_out` and clear the underrun counter.
- On `sample_tick` with the FIFO empty: set `underrun_flag` and increment the saturating underrun counter. `pcm_out` holds its last value; once the counter reaches MUTE_AFTER, `pcm_out` is 0.
- Push and pop in the same cycle are both performed; the level is unchanged. A pop on an empty FIFO never happens, because push-same-cycle does not bypass. WRITE push when full never happens with a simultaneous pop: full is evaluated before the pop, so the sample is dropped.
- `clear_flags` clears all three sticky flags. If an error event occurs in the same cycle, the event wins and the flag stays set.
- Pointers wrap modulo FIFO_DEPTH. `fifo_level` is in the range 0..FIFO_DEPTH.

## Timing
- Reset values: state IDLE, tick counter 0, FIFO empty, underrun counter 0. All outputs are 0: `dsp_start`, `dsp_data`, `pcm_out`, `sample_tick`, all flags, `fifo_level`.
- Reset asserted mid-transaction aborts immediately. A late `dsp_done` after reset release is ignored, because the FSM is in IDLE.
- Latency: `rx_valid` at cycle N gives `dsp_start` at N+1. `dsp_done` at cycle M makes the entry visible in `fifo_level` at M+2, via WRITE at M+1.
- Minimum accept spacing is 4 cycles with a 1-cycle DSP; `rx_valid` can be accepted again in the cycle after WRITE.
- First `sample_tick` occurs RATE_DIV cycles after reset release. `pcm_out` updates in the cycle after `sample_tick`, registered.
- All outputs are registered; there are no combinational in-to-out paths.

## Test plan
- Single sample: `rx_data`=0x1234, DSP returns 0x0F0F after 3 cycles. Required: `dsp_start` one cycle at N+1, `dsp_data`=0x1234, `fifo_level`=1, `pcm_out`=0x0F0F after the next tick, no flags set.
- Back-to-back `rx_valid` on consecutive cycles: the second sample is dropped, `overrun_flag`=1, and only one `dsp_start` is issued.
- DSP never answers: `timeout_flag`=1 exactly DSP_TIMEOUT cycles after `dsp_start`, FSM back in IDLE, a new `rx_valid` is accepted.
- Feed 6 samples between ticks with DEPTH=4: 4 are stored, 2 dropped with `overrun_flag`=1, and the ticks drain them in order.
- No input for 10 ticks after last value 0x7FFF: `pcm_out`=0x7FFF for 7 ticks, then 0 from the 8th tick, `underrun_flag`=1. `clear_flags` clears it, and the flag is re-set by the next empty tick.
- Assert `reset` in WAIT with the FIFO holding 2 entries: all outputs go to 0 immediately, and a later `dsp_done` produces no FIFO push.

Source files
------------

// File: rtl/audio_sample_scheduler_if.sv
`timescale 1ns/1ps
// Signal bundle between the sample scheduler and its SPI receiver, DSP, DAC and status logic.
// The master modport is the scheduler's view; slave is the surrounding system's view.
interface audio_sample_scheduler_if #(
    parameter int DATA_W  = 16,
    parameter int LEVEL_W = 3
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              dsp_start;
    logic [DATA_W-1:0] dsp_data;
    logic              dsp_done;
    logic [DATA_W-1:0] dsp_result;
    logic [DATA_W-1:0] pcm_out;
    logic              sample_tick;
    logic              clear_flags;
    logic              overrun_flag;
    logic              underrun_flag;
    logic              timeout_flag;
    logic [LEVEL_W-1:0] fifo_level;

    modport master (
        input  rx_valid, rx_data, dsp_done, dsp_result, clear_flags,
        output dsp_start, dsp_data, pcm_out, sample_tick,
               overrun_flag, underrun_flag, timeout_flag, fifo_level
    );

    modport slave (
        output rx_valid, rx_data, dsp_done, dsp_result, clear_flags,
        input  dsp_start, dsp_data, pcm_out, sample_tick,
               overrun_flag, underrun_flag, timeout_flag, fifo_level
    );
endinterface

// File: rtl/audio_sample_scheduler.sv
`timescale 1ns/1ps
// Per-sample sequencer: one received PCM word -> one DSP transaction -> result FIFO -> DAC at a
// fixed sample tick. Drops on overrun, holds then mutes on underrun, keeps sticky error flags.
module audio_sample_scheduler #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int RATE_DIV    = 256,
    parameter int DSP_TIMEOUT = 64,
    parameter int MUTE_AFTER  = 8
) (
    input  logic                     input_clk,
    input  logic                     reset,
    audio_sample_scheduler_if.master bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int TICK_W = $clog2(RATE_DIV);
    localparam int TMO_W  = $clog2(DSP_TIMEOUT + 1);
    localparam int UND_W  = $clog2(MUTE_AFTER + 1);

    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RATE_DIV - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DSP_TIMEOUT - 1);
    localparam logic [UND_W-1:0]  UND_SAT   = UND_W'(MUTE_AFTER);
    localparam logic [UND_W-1:0]  UND_MUTE  = UND_W'(MUTE_AFTER - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                accept_s;
    logic                timeout_s;
    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                empty_s;
    logic                overrun_set_s;
    logic                underrun_set_s;

    logic [DATA_W-1:0]   dsp_data_r;
    logic                dsp_start_r;
    logic [DATA_W-1:0]   result_r;
    logic [TMO_W-1:0]    tmo_cnt_r;

    logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [LVL_W-1:0]    level_r;

    logic [TICK_W-1:0]   tick_cnt_r;
    logic                tick_r;
    logic [DATA_W-1:0]   pcm_r;
    logic [UND_W-1:0]    und_cnt_r;

    logic                overrun_r;
    logic                underrun_r;
    logic                timeout_r;

    // FSM state register
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus the per-cycle strobes that drive datapath and flags
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        timeout_s = 1'b0;
        push_s    = 1'b0;
        full_s    = (level_r == LVL_FULL);
        empty_s   = (level_r == {LVL_W{1'b0}});
        case (state_r)
            IDLE: begin
                if (bus.rx_valid) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                // A completion in the last window cycle still counts.
                if (bus.dsp_done) begin
                    state_s = WRITE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            WRITE: begin
                push_s  = !full_s;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        pop_s          = tick_r && !empty_s;
        overrun_set_s  = (bus.rx_valid && (state_r != IDLE)) || ((state_r == WRITE) && full_s);
        underrun_set_s = tick_r && empty_s;
    end

    // DSP operand, start pulse, result capture; the counter reads 0 during the ISSUE cycle
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            dsp_data_r  <= {DATA_W{1'b0}};
            dsp_start_r <= 1'b0;
            result_r    <= {DATA_W{1'b0}};
            tmo_cnt_r   <= {TMO_W{1'b0}};
        end else begin
            dsp_start_r <= accept_s;
            if (accept_s) begin
                dsp_data_r <= bus.rx_data;
            end
            if ((state_r == WAIT) && bus.dsp_done) begin
                result_r <= bus.dsp_result;
            end
            if (state_r == IDLE) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else if ((state_r == ISSUE) || (state_r == WAIT)) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
        end
    end

    // Result FIFO; fullness is judged before any same-cycle pop
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= result_r;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sample-rate tick and DAC output with hold-then-mute on consecutive underruns
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            tick_r     <= 1'b0;
            pcm_r      <= {DATA_W{1'b0}};
            und_cnt_r  <= {UND_W{1'b0}};
        end else begin
            tick_cnt_r <= (tick_cnt_r == TICK_LAST) ? {TICK_W{1'b0}} : tick_cnt_r + TICK_W'(1);
            tick_r     <= (tick_cnt_r == TICK_LAST);
            if (pop_s) begin
                pcm_r     <= mem_r[rd_ptr_r];
                und_cnt_r <= {UND_W{1'b0}};
            end else if (underrun_set_s) begin
                if (und_cnt_r != UND_SAT) begin
                    und_cnt_r <= und_cnt_r + UND_W'(1);
                end
                if (und_cnt_r >= UND_MUTE) begin
                    pcm_r <= {DATA_W{1'b0}};
                end
            end
        end
    end

    // Sticky flags; a new event outranks a same-cycle clear
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (bus.clear_flags) begin
                overrun_r <= 1'b0;
            end
            if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end else if (bus.clear_flags) begin
                underrun_r <= 1'b0;
            end
            if (timeout_s) begin
                timeout_r <= 1'b1;
            end else if (bus.clear_flags) begin
                timeout_r <= 1'b0;
            end
        end
    end

    assign bus.dsp_start     = dsp_start_r;
    assign bus.dsp_data      = dsp_data_r;
    assign bus.pcm_out       = pcm_r;
    assign bus.sample_tick   = tick_r;
    assign bus.overrun_flag  = overrun_r;
    assign bus.underrun_flag = underrun_r;
    assign bus.timeout_flag  = timeout_r;
    assign bus.fifo_level    = level_r;

endmodule
